// File: rtl/vc_data_array_nway.sv
// vc_data_array_nway: n-entry victim-cache line store with byte-masked writes and forwarded 1-cycle reads; VC_DATA_PARITY_EN adds per-byte parity
module vc_data_array_nway #(
    parameter int s_line      = 256,
    parameter int s_mask      = 32,
    parameter int num_entries = 4,
    parameter int s_index     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   read,
    input  logic [s_index-1:0]     read_idx,
    input  logic [s_mask-1:0]      write_en,
    input  logic [s_index-1:0]     write_idx,
    input  logic [s_line-1:0]      datain,
    input  logic                   inval,
    input  logic [s_index-1:0]     inval_idx,
    output logic [s_line-1:0]      dataout,
    output logic                   rvalid,
    output logic                   line_valid,
    output logic [num_entries-1:0] valid_vec,
    output logic                   parity_err
);
    logic [s_line-1:0]      lines [num_entries];
    logic [num_entries-1:0] valid;
    logic [s_line-1:0]      bmask, rd_line, fwd_line;
    logic                   wr, inv, rd_hit, same, rd_valid, fwd_valid;
    assign wr     = |write_en && int'(write_idx) < num_entries;
    assign inv    = inval && int'(inval_idx) < num_entries;
    assign rd_hit = int'(read_idx) < num_entries;
    assign same   = wr && write_idx == read_idx;
    genvar b;
    for (b = 0; b < s_mask; b++) begin : g_mask
        assign bmask[8*b +: 8] = {8{write_en[b]}};
    end
    always_comb begin
        rd_line  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < num_entries; i++) begin
            if (int'(read_idx) == i) begin
                rd_line  = lines[i];
                rd_valid = valid[i];
            end
        end
    end
    // The returned line and valid bit reflect this cycle's write/invalidate.
    assign fwd_line  = same ? (rd_line & ~bmask) | (datain & bmask) : rd_line;
    assign fwd_valid = rd_hit && (same || (rd_valid && !(inv && inval_idx == read_idx)));
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < num_entries; i++) lines[i] <= '0;
            valid      <= '0;
            dataout    <= '0;
            rvalid     <= 1'b0;
            line_valid <= 1'b0;
        end else begin
            for (int i = 0; i < num_entries; i++) begin
                if (wr && int'(write_idx) == i) lines[i] <= (lines[i] & ~bmask) | (datain & bmask);
                valid[i] <= (wr && int'(write_idx) == i) || (valid[i] && !(inv && int'(inval_idx) == i));
            end
            rvalid <= read;
            if (read) begin
                dataout    <= fwd_line;
                line_valid <= fwd_valid;
            end
        end
    end
    assign valid_vec = valid;
`ifdef VC_DATA_PARITY_EN
    logic [num_entries-1:0][s_mask-1:0] par;
    logic [s_mask-1:0]                  dpar, rd_par, fwd_par, calc_par;
    for (b = 0; b < s_mask; b++) begin : g_par
        assign dpar[b]     = ^datain[8*b +: 8];
        assign calc_par[b] = ^fwd_line[8*b +: 8];
    end
    always_comb begin
        rd_par = '0;
        for (int i = 0; i < num_entries; i++) begin
            if (int'(read_idx) == i) rd_par = par[i];
        end
    end
    assign fwd_par = same ? (rd_par & ~write_en) | (dpar & write_en) : rd_par;
    always_ff @(posedge clk) begin
        if (rst) begin
            par        <= '0;
            parity_err <= 1'b0;
        end else begin
            for (int i = 0; i < num_entries; i++) begin
                if (wr && int'(write_idx) == i) par[i] <= (par[i] & ~write_en) | (dpar & write_en);
            end
            parity_err <= read && rd_hit && |(calc_par ^ fwd_par);
        end
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_vc_data_array_nway.sv
// tb_vc_data_array_nway: directed + random scoreboard bench for vc_data_array_nway (3 entries, 32-bit lines)
module tb_vc_data_array_nway;
    localparam int SL = 32, SM = 4, NE = 3, SI = 2;
    logic          clk = 1'b0;
    logic          rst, read, inval;
    logic [SI-1:0] read_idx, write_idx, inval_idx;
    logic [SM-1:0] write_en;
    logic [SL-1:0] datain, dataout;
    logic          rvalid, line_valid, parity_err;
    logic [NE-1:0] valid_vec;
    vc_data_array_nway #(.s_line(SL), .s_mask(SM), .num_entries(NE), .s_index(SI)) dut (
        .clk(clk), .rst(rst), .read(read), .read_idx(read_idx), .write_en(write_en),
        .write_idx(write_idx), .datain(datain), .inval(inval), .inval_idx(inval_idx),
        .dataout(dataout), .rvalid(rvalid), .line_valid(line_valid),
        .valid_vec(valid_vec), .parity_err(parity_err)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [SL-1:0] d;
        logic          v;
    } exp_t;
    exp_t          q[$];
    logic [SL-1:0] m_line [NE];
    logic [NE-1:0] m_val;
    logic [SL-1:0] last_d;
    logic          last_v;
    logic          exp_perr;
    int            tests = 0, fails = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // One clock of stimulus; the model is updated first so reads see same-cycle writes.
    task automatic cyc(input logic r, input logic [SI-1:0] ri, input logic [SM-1:0] we,
                       input logic [SI-1:0] wi, input logic [SL-1:0] d,
                       input logic iv, input logic [SI-1:0] ii);
        exp_t e;
        read = r; read_idx = ri; write_en = we; write_idx = wi; datain = d;
        inval = iv; inval_idx = ii;
        if (iv && int'(ii) < NE) m_val[ii] = 1'b0;
        if (|we && int'(wi) < NE) begin
            for (int k = 0; k < SM; k++) if (we[k]) m_line[wi][8*k +: 8] = d[8*k +: 8];
            m_val[wi] = 1'b1;
        end
        if (r) begin
            e = '0;
            if (int'(ri) < NE) e = {m_line[ri], m_val[ri]};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("rvalid", rvalid, r);
        if (r) begin
            e = q.pop_front();
            last_d = e.d;
            last_v = e.v;
            check("parity_err", parity_err, exp_perr);
        end
        check("dataout", dataout, last_d);
        check("line_valid", line_valid, last_v);
        check("valid_vec", valid_vec, m_val);
    endtask
    task automatic reset_cyc(input logic r, input logic [SM-1:0] we);
        rst = 1'b1; read = r; read_idx = 0; write_en = we; write_idx = 0;
        datain = 32'hCAFEF00D; inval = 1'b0; inval_idx = 0;
        for (int i = 0; i < NE; i++) m_line[i] = '0;
        m_val = '0; last_d = '0; last_v = 1'b0;
        @(posedge clk);
        #1;
        check("rst_dataout", dataout, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_line_valid", line_valid, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_valid_vec", valid_vec, 0);
        rst = 1'b0;
    endtask
    initial begin
        exp_perr = 1'b0;
        reset_cyc(1'b0, 4'h0);
        reset_cyc(1'b1, 4'hF);
        for (int i = 0; i < NE; i++) cyc(1, SI'(i), 0, 0, 0, 0, 0);
        cyc(0, 0, 4'hF, 1, 32'hAABBCCDD, 0, 0);
        cyc(0, 0, 4'b0101, 1, 32'h11223344, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("merge", dataout, 32'hAA22CC44);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("hold", dataout, 32'hAA22CC44);
        cyc(0, 0, 4'hF, 2, 32'h12345678, 0, 0);
        cyc(1, 2, 4'b0011, 2, 32'hDEADBEEF, 0, 0);
        check("fwd", dataout, 32'h1234BEEF);
        check("fwd_lv", line_valid, 1);
        cyc(0, 0, 4'h1, 1, 32'h000000EE, 1, 1);
        check("wr_beats_inval", valid_vec[1], 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("inval_only", valid_vec[1], 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check("inval_data_kept", dataout, 32'hAA22CCEE);
        check("inval_lv", line_valid, 0);
        cyc(0, 0, 4'h2, 1, 32'h00005500, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 1);
        check("read_inval_same", line_valid, 0);
        cyc(0, 0, 4'hF, 0, 32'h0BADF00D, 1, 2);
        check("both_take_effect", valid_vec, 3'b001);
        cyc(0, 0, 4'hF, 3, 32'hFFFFFFFF, 0, 0);
        check("oor_write", valid_vec, 3'b001);
        cyc(1, 3, 0, 0, 0, 1, 3);
        check("oor_read_d", dataout, 0);
        check("oor_read_lv", line_valid, 0);
        for (int i = 0; i < 40; i++)
            cyc($urandom_range(0, 1) == 1, SI'($urandom_range(0, 3)), SM'($urandom),
                SI'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0, SI'($urandom_range(0, 3)));
`ifdef VC_DATA_PARITY_EN
        begin
            logic [NE-1:0][SM-1:0] pv;
            cyc(0, 0, 4'hF, 0, 32'h01020304, 0, 0);
            pv = dut.par;
            pv[0][0] = ~pv[0][0];
            force dut.par = pv;
            exp_perr = 1'b1;
            cyc(1, 0, 0, 0, 0, 0, 0);
            exp_perr = 1'b0;
            release dut.par;
        end
`endif
        reset_cyc(1'b1, 4'hF);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("post_rst_line", dataout, 0);
        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
